pipe_ctrl: RTL

Pipeline control unit for the 5-stage core. It merges per-stage stall requests into the 6-bit `stall_ctrl` vector consumed by every inter-stage pipeline register, and sequences exception and `eret` entry. Sequencing runs as freeze, then a one-cycle `flush` with the redirect PC, then a short exception-shadow window. Optionally, a stall watchdog flags runaway stalls.

---
 rtl/pipe_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall merge plus exception/eret freeze-flush-drain sequencing
//   in : clk, rst (sync, active-high), stallreq_{if,id,ex,mem}, excp_valid, excp_is_eret, cp0_epc
//   out: stall_ctrl[5:0] (PC,IF,ID,EX,MEM,WB hold), flush, new_pc, excp_ack, stall_timeout
//   `PIPE_CTRL_STALL_WDOG_EN enables the runaway-stall watchdog; otherwise stall_timeout is 0
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0020,
  parameter int SHADOW_CYCLES = 2,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic              excp_is_eret,
  input  logic [ADDR_W-1:0] cp0_epc,
  output logic [5:0]        stall_ctrl,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              excp_ack,
  output logic              stall_timeout
);
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [5:0] dec;
  if (SHADOW_CYCLES < 1 || SHADOW_CYCLES > 3 || WDOG_LIMIT < 1) begin : g_bad_cfg
    $error("pipe_ctrl: illegal SHADOW_CYCLES or WDOG_LIMIT");
  end
  always_comb dec = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
                    stallreq_id  ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    stall_ctrl = dec;
    flush      = 1'b0;
    excp_ack   = 1'b0;
    case (state)
      RUN: if (excp_valid) begin
        stall_ctrl = 6'b111111;
        state_nx   = FLUSH;
      end
      FLUSH: begin
        stall_ctrl = 6'b000000;
        flush      = 1'b1;
        excp_ack   = 1'b1;
        state_nx   = DRAIN;
        cnt_nx     = 2'(SHADOW_CYCLES - 1);
      end
      DRAIN: if (!dec[4]) begin
        // a held MEM stage freezes the shadow window
        if (cnt == 2'd0) state_nx = RUN;
        else cnt_nx = cnt - 2'd1;
      end
      default: state_nx = RUN;
    endcase
    if (rst) begin
      stall_ctrl = 6'b000000;
      flush      = 1'b0;
      excp_ack   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= 2'd0;
      new_pc <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == RUN && excp_valid) new_pc <= excp_is_eret ? cp0_epc : EXC_VECTOR;
    end
  end
`ifdef PIPE_CTRL_STALL_WDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] wcnt;
  logic stalled;
  // stall_ctrl is already 0 in FLUSH and under reset, so this also clears there
  always_comb stalled = |stall_ctrl;
  always_ff @(posedge clk) begin
    if (rst || !stalled) wcnt <= '0;
    else if (wcnt != WW'(WDOG_LIMIT)) wcnt <= wcnt + 1'b1;
  end
  always_comb stall_timeout = stalled && wcnt == WW'(WDOG_LIMIT - 1);
`else
  always_comb stall_timeout = 1'b0;
`endif
endmodule
